// File: rtl/vx_gbar_pkg.sv
// vx_gbar_pkg: shared types and constants for the cluster global barrier arbiter.
package vx_gbar_pkg;
    localparam int GBAR_NUM_REQS     = 4;
    localparam int GBAR_NUM_BARRIERS = 8;
    localparam int GBAR_NC_W         = $clog2(GBAR_NUM_REQS);
    localparam int GBAR_NB_W         = $clog2(GBAR_NUM_BARRIERS);
    localparam logic [1:0] GBAR_ERR_DUP  = 2'd1;
    localparam logic [1:0] GBAR_ERR_SIZE = 2'd2;
    typedef enum logic {GBAR_IDLE, GBAR_COLLECT} gbar_state_e;
    typedef struct packed {
        gbar_state_e                state;
        logic [GBAR_NC_W:0]         ctr;
        logic [GBAR_NC_W-1:0]       size;
        logic [GBAR_NUM_REQS-1:0]   mask;
    } gbar_entry_t;
endpackage

// File: rtl/vx_gbar_arbiter_if.sv
// vx_gbar_arbiter_if: core-side arrival requests and the broadcast release/error bus.
interface vx_gbar_arbiter_if
    import vx_gbar_pkg::*;
#(
    parameter int NUM_REQS = GBAR_NUM_REQS,
    parameter int NB_W     = GBAR_NB_W,
    parameter int NC_W     = GBAR_NC_W
);
    logic [NUM_REQS-1:0]            req_valid;
    logic [NUM_REQS-1:0][NB_W-1:0]  req_id;
    logic [NUM_REQS-1:0][NC_W-1:0]  req_size_m1;
    logic [NUM_REQS-1:0]            req_ready;
    logic                           rsp_valid;
    logic [NB_W-1:0]                rsp_id;
    logic                           err_valid;
    logic [1:0]                     err_code;
    logic                           busy;
    modport master (
        output req_valid, req_id, req_size_m1,
        input  req_ready, rsp_valid, rsp_id, err_valid, err_code, busy
    );
    modport slave (
        input  req_valid, req_id, req_size_m1,
        output req_ready, rsp_valid, rsp_id, err_valid, err_code, busy
    );
endinterface

// File: rtl/vx_gbar_rr_arbiter.sv
// vx_gbar_rr_arbiter: round-robin one-hot grant; the pointer moves past each granted requester.
module vx_gbar_rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] valid,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx
);
    logic [W-1:0] ptr;
    logic         found;
    int           idx;
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = W'(idx);
            end
        end
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            ptr <= '0;
        else if (found)
            ptr <= (int'(grant_idx) == N - 1) ? '0 : W'(int'(grant_idx) + 1);
endmodule

// File: rtl/vx_gbar_arbiter.sv
// vx_gbar_arbiter: accepts one barrier arrival per cycle and broadcasts a registered
// release when the last participating core of a barrier arrives.
module vx_gbar_arbiter
    import vx_gbar_pkg::*;
#(
    parameter int NUM_REQS     = GBAR_NUM_REQS,
    parameter int NUM_BARRIERS = GBAR_NUM_BARRIERS,
    parameter int NB_W         = $clog2(NUM_BARRIERS),
    parameter int NC_W         = $clog2(NUM_REQS)
) (
    input  logic               clk,
    input  logic               reset_n,
    vx_gbar_arbiter_if.slave   bus
);
    localparam logic [NC_W:0] CTR_ONE = 1;
    logic [NUM_REQS-1:0]                  grant;
    logic [NC_W-1:0]                      g;
    logic                                 fire;
    logic [NB_W-1:0]                      id;
    logic [NC_W-1:0]                      sz;
    gbar_entry_t [NUM_BARRIERS-1:0]       ent;
    gbar_entry_t                          cur;
    logic [NUM_BARRIERS-1:0]              collect_nxt;
    logic                                 collect, dup, mism, rel;
    vx_gbar_rr_arbiter #(.N(NUM_REQS), .W(NC_W)) u_rr (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid     (bus.req_valid),
        .grant     (grant),
        .grant_idx (g)
    );
    assign bus.req_ready = grant;
    assign fire = |grant;
    assign id   = bus.req_id[g];
    assign sz   = bus.req_size_m1[g];
    assign cur  = ent[id];
    // Error and release decisions only ever concern the barrier addressed by the winning core.
    always_comb begin
        collect = cur.state == GBAR_COLLECT;
        dup     = collect && cur.mask[g];
        mism    = collect && sz != cur.size;
        rel     = fire && !dup && !mism && (collect ? cur.ctr == {1'b0, cur.size} : sz == '0);
    end
    for (genvar b = 0; b < NUM_BARRIERS; b++) begin : g_bar
        gbar_entry_t q, d;
        logic        hit;
        assign hit = fire && !dup && !mism && id == NB_W'(b);
        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n)
                q <= '0;
            else
                q <= d;
        always_comb begin
            d = q;
            if (hit && q.state == GBAR_IDLE && sz != '0)
                d = gbar_entry_t'{state: GBAR_COLLECT, ctr: CTR_ONE, size: sz, mask: grant};
            else if (hit && q.state == GBAR_COLLECT)
                d = (q.ctr == {1'b0, q.size})
                    ? gbar_entry_t'{state: GBAR_IDLE, ctr: '0, size: q.size, mask: '0}
                    : gbar_entry_t'{state: GBAR_COLLECT, ctr: q.ctr + CTR_ONE, size: q.size, mask: q.mask | grant};
        end
        assign ent[b]         = q;
        assign collect_nxt[b] = d.state == GBAR_COLLECT;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.err_valid <= 1'b0;
            bus.err_code  <= '0;
            bus.busy      <= 1'b0;
        end else begin
            bus.rsp_valid <= rel;
            bus.rsp_id    <= rel ? id : bus.rsp_id;
            bus.err_valid <= fire && (dup || mism);
            bus.err_code  <= !fire ? '0 : dup ? GBAR_ERR_DUP : mism ? GBAR_ERR_SIZE : '0;
            bus.busy      <= |collect_nxt;
        end
endmodule

// File: tb/tb_vx_gbar_arbiter.sv
// tb_vx_gbar_arbiter: directed vector table, hand sequences and a randomized run
// against an arrival-counting barrier model.
module tb_vx_gbar_arbiter;
    import vx_gbar_pkg::*;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;
    vx_gbar_arbiter_if bus ();
    vx_gbar_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    int tests = 0;
    int fails = 0;
    typedef struct {
        int core; int id; int sz; int ready; int rsp; int rid; int err; int code; int busy;
    } vec_t;
    vec_t tbl[18];
    int   cnt[4], want[4], fsz[4];
    bit   active[4];
    bit [3:0] seen[4];
    int   ptr;
    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask
    task automatic step(input logic [3:0] v, input logic [3:0][2:0] ids,
                        input logic [3:0][1:0] szs, output logic [3:0] rdy);
        bus.req_valid   = v;
        bus.req_id      = ids;
        bus.req_size_m1 = szs;
        #1 rdy = bus.req_ready;
        @(posedge clk);
        #1 bus.req_valid = '0;
    endtask
    task automatic one(input int core, input int id, input int sz, output logic [3:0] rdy);
        logic [2:0] i3;
        logic [1:0] s2;
        i3 = 3'(id);
        s2 = 2'(sz);
        step(core < 0 ? 4'b0 : 4'(1 << core), {4{i3}}, {4{s2}}, rdy);
    endtask
    initial begin
        #200000 $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end
    initial begin
        logic [3:0] rdy, v;
        logic [3:0][2:0] ids;
        logic [3:0][1:0] szs;
        int g, erel, eid, eerr, ecode, ebusy;
        tbl = '{
            '{0,2,3, 1,0,0,0,0,1}, '{1,2,3, 2,0,0,0,0,1}, '{2,2,3, 4,0,0,0,0,1}, '{3,2,3, 8,1,2,0,0,0},
            '{0,1,1, 1,0,0,0,0,1}, '{1,4,1, 2,0,0,0,0,1}, '{2,1,1, 4,1,1,0,0,1}, '{3,4,1, 8,1,4,0,0,0},
            '{1,3,2, 2,0,0,0,0,1}, '{1,3,2, 2,0,0,1,1,1}, '{2,3,1, 4,0,0,1,2,1}, '{2,3,2, 4,0,0,0,0,1},
            '{0,3,2, 1,1,3,0,0,0}, '{0,0,0, 1,1,0,0,0,0}, '{1,5,1, 2,0,0,0,0,1}, '{1,5,2, 2,0,0,1,1,1},
            '{3,5,1, 8,1,5,0,0,0}, '{-1,0,0, 0,0,0,0,0,0}
        };
        fsz = '{1, 3, 2, 0};
        bus.req_valid = '0;
        bus.req_id = '0;
        bus.req_size_m1 = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_err_valid", bus.err_valid, 0);
        chk("rst_err_code", bus.err_code, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready_idle", bus.req_ready, 0);
        bus.req_valid = 4'b1111;
        #1 chk("rst_ptr_zero", bus.req_ready, 1);
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            one(tbl[i].core, tbl[i].id, tbl[i].sz, rdy);
            chk($sformatf("vec%0d_ready", i), rdy, tbl[i].ready);
            chk($sformatf("vec%0d_rsp_valid", i), bus.rsp_valid, tbl[i].rsp);
            if (tbl[i].rsp != 0) chk($sformatf("vec%0d_rsp_id", i), bus.rsp_id, tbl[i].rid);
            chk($sformatf("vec%0d_err_valid", i), bus.err_valid, tbl[i].err);
            if (tbl[i].err != 0) chk($sformatf("vec%0d_err_code", i), bus.err_code, tbl[i].code);
            chk($sformatf("vec%0d_busy", i), bus.busy, tbl[i].busy);
        end
        // Two arrivals on id6 plus an immediate release, then reset between edges.
        one(1, 6, 3, rdy);
        one(2, 6, 3, rdy);
        one(3, 0, 0, rdy);
        chk("pre_rst_rsp_valid", bus.rsp_valid, 1);
        chk("pre_rst_busy", bus.busy, 1);
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_rsp_valid", bus.rsp_valid, 0);
        chk("async_rst_busy", bus.busy, 0);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            one(k, 6, 3, rdy);
            chk($sformatf("post_rst%0d_ready", k), rdy, 1 << k);
            chk($sformatf("post_rst%0d_rsp_valid", k), bus.rsp_valid, k == 3);
            chk($sformatf("post_rst%0d_err_valid", k), bus.err_valid, 0);
        end
        chk("post_rst_rsp_id", bus.rsp_id, 6);
        v = 4'b1111;
        ids = {4{3'd5}};
        szs = {4{2'd3}};
        for (int k = 0; k < 4; k++) begin
            step(v, ids, szs, rdy);
            chk($sformatf("arb%0d_ready", k), rdy, 1 << k);
            chk($sformatf("arb%0d_rsp_valid", k), bus.rsp_valid, k == 3);
            v &= ~rdy;
        end
        chk("arb_rsp_id", bus.rsp_id, 5);
        chk("arb_busy", bus.busy, 0);
        ids = {4{3'd7}};
        one(2, 7, 3, rdy);
        chk("persist_setup_ready", rdy, 4);
        v = 4'b1101;
        step(v, ids, szs, rdy);
        chk("persist_g3", rdy, 8);
        v = 4'b0101;
        step(v, ids, szs, rdy);
        chk("persist_g0", rdy, 1);
        v = 4'b0100;
        step(v, ids, szs, rdy);
        chk("persist_g2", rdy, 4);
        chk("persist_dup_err", bus.err_valid, 1);
        chk("persist_dup_code", bus.err_code, 1);
        chk("persist_busy", bus.busy, 1);
        // Randomized phase against the arrival-counting model.
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        ptr = 0;
        for (int b = 0; b < 4; b++) begin
            active[b] = 0; cnt[b] = 0; want[b] = 0; seen[b] = '0;
        end
        for (int n = 0; n < 400; n++) begin
            v = 4'($urandom_range(0, 15));
            for (int c = 0; c < 4; c++) begin
                ids[c] = 3'($urandom_range(0, 3));
                szs[c] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'(fsz[ids[c]]);
            end
            g = -1;
            for (int k = 0; k < 4; k++)
                if (g < 0 && v[(ptr + k) % 4]) g = (ptr + k) % 4;
            erel = 0; eid = 0; eerr = 0; ecode = 0;
            if (g >= 0) begin
                eid = ids[g];
                if (active[eid]) begin
                    if (seen[eid][g]) begin eerr = 1; ecode = 1; end
                    else if (int'(szs[g]) != want[eid]) begin eerr = 1; ecode = 2; end
                    else begin
                        seen[eid][g] = 1'b1;
                        cnt[eid]++;
                        if (cnt[eid] == want[eid] + 1) begin erel = 1; active[eid] = 0; end
                    end
                end else if (szs[g] == 0) erel = 1;
                else begin
                    active[eid] = 1; want[eid] = szs[g]; cnt[eid] = 1; seen[eid] = 4'(1 << g);
                end
                ptr = (g + 1) % 4;
            end
            ebusy = 0;
            for (int b = 0; b < 4; b++) if (active[b]) ebusy = 1;
            step(v, ids, szs, rdy);
            chk($sformatf("rnd%0d_ready", n), rdy, g < 0 ? 0 : 1 << g);
            chk($sformatf("rnd%0d_rsp_valid", n), bus.rsp_valid, erel);
            if (erel != 0) chk($sformatf("rnd%0d_rsp_id", n), bus.rsp_id, eid);
            chk($sformatf("rnd%0d_err_valid", n), bus.err_valid, eerr);
            if (eerr != 0) chk($sformatf("rnd%0d_err_code", n), bus.err_code, ecode);
            chk($sformatf("rnd%0d_busy", n), bus.busy, ebusy);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vx_gbar_arbiter.md
Name: vx_gbar_arbiter

Overview:
- Cluster-level global barrier arbiter. Sits between the per-core scheduler global-barrier request ports and the broadcast response bus.
- Arbitrates arrival requests from NUM_REQS cores, one per cycle, round-robin.
- Tracks per-barrier arrival count, core mask and expected size.
- When the last core arrives, broadcasts a one-cycle release (rsp_valid, rsp_id) to all cores.

Parameters:
- NUM_REQS, 4, number of requesting cores (≥2).
- NUM_BARRIERS, 8, number of global barrier ids.
- NB_W, $clog2(NUM_BARRIERS), barrier id width.
- NC_W, $clog2(NUM_REQS), core index and size_m1 width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQS  per-core arrival request.
- req_id  in  NUM_REQS x NB_W  barrier id per core.
- req_size_m1  in  NUM_REQS x NC_W  participating cores minus 1.
- req_ready  out  NUM_REQS  one-hot grant; a request fires on valid&&ready.
- rsp_valid  out  1  release broadcast, one-cycle pulse.
- rsp_id  out  NB_W  released barrier id.
- err_valid  out  1  one-cycle pulse on a protocol error.
- err_code  out  2  1 = duplicate arrival, 2 = size mismatch.
- busy  out  1  some barrier is in COLLECT.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is asynchronous and active-low, reset_n.
- Reset values:
  - rsp_valid=0, rsp_id=0, err_valid=0, err_code=0, busy=0.
  - All barriers IDLE, with ctr=0, mask=0, size=0.
  - Round-robin pointer = 0 (core 0 has highest priority first).
- Arbitration:
  - req_ready is combinational: one-hot on the first valid core at or after the RR pointer, cyclically.
  - req_ready is all-zero when no core is valid.
  - req_ready must not depend on the request's barrier state: requests are never back-pressured except by arbitration.
  - After a grant to core g, the pointer becomes (g+1) mod NUM_REQS. With no grant, the pointer holds.
- Per-barrier FSM, two states:
  - IDLE --grant, size_m1>0--> COLLECT: store size=size_m1, ctr=1, mask=onehot(g).
  - IDLE --grant, size_m1==0--> IDLE: immediate release.
  - COLLECT --grant from new core, ctr==size--> IDLE: release; clear ctr and mask.
  - COLLECT --grant from new core, ctr<size--> COLLECT: ctr+1, mask|=onehot(g).
- Width rules:
  - ctr is NC_W+1 bits.
  - Compare ctr against the zero-extended size; no wrap is possible because ctr ≤ size ≤ NUM_REQS-1.
- Release: registered. A grant accepted in cycle t gives rsp_valid=1 and rsp_id=id in cycle t+1, for exactly one cycle. At most one release per cycle, so there is no queuing.
- Errors (registered, t+1). State is unchanged, but the request is still consumed (ready=1):
  - Duplicate arrival: in COLLECT and mask[g]==1 → err_code=1.
  - Size mismatch: in COLLECT and size_m1 != stored size → err_code=2.
  - If both apply, duplicate wins.
- Same-cycle interaction: a release of id X in t+1 and a new grant to id X in t+1 are legal. The new grant sees IDLE, since state was updated at the t edge.
- busy = OR of (state==COLLECT) over all barriers, registered.
- Reset asserted mid-collection: all barrier state is dropped immediately (async) and no release is emitted. Cores must re-issue.
- Outputs are glitch-free registers, except req_ready.

Decomposition:
- Shared package vx_gbar_pkg holds:
  - typedef gbar_state_e {GBAR_IDLE, GBAR_COLLECT}.
  - typedef gbar_entry_t {state, ctr, size, mask}.
  - Constants GBAR_ERR_DUP=1 and GBAR_ERR_SIZE=2.
- Sub-module vx_gbar_rr_arbiter: NUM_REQS-wide round-robin grant with pointer register and the same reset.
- Per-barrier entry update logic is a generate loop inside the top module.

Test Plan:
- Basic release: cores 0..3 each send id=2, size_m1=3, one per cycle.
  - rsp_valid=0 through the third grant.
  - rsp_valid=1, rsp_id=2 the cycle after the 4th grant.
  - busy returns to 0.
- Arbitration: all 4 cores valid in the same cycle with id=5, size_m1=3.
  - Grants go 0,1,2,3 on consecutive cycles.
  - rsp_valid pulses once, with rsp_id=5, the cycle after grant 3.
  - With a persistent request on core 2 and the pointer at 3: grant order is 3 (if valid), then 0, then 2.
- Interleaved ids: core0 sends id1 (size_m1=1), core1 sends id4 (size_m1=1), core2 sends id1, core3 sends id4.
  - Releases: rsp_id=1, then rsp_id=4, on the two cycles after the respective grants.
- Errors:
  - Core1 sends id3 (size_m1=2) twice → second grant gives err_valid=1, err_code=1, ctr stays 1.
  - Core2 sends id3 with size_m1=1 → err_code=2.
  - No rsp_valid is emitted for either.
- Immediate release: core0 sends id0 with size_m1=0 → rsp_valid=1, rsp_id=0 next cycle; busy stays 0.
- Async reset mid-collection: 2 of 4 arrivals on id6, then reset_n=0 between clock edges.
  - Outputs and busy go to 0 without waiting for a clock edge.
  - After reset, 4 new arrivals are needed before rsp_id=6 is released.
